// File: rtl/cache_pkg.sv
// Shared op codes and FSM states for the L1 way store.
// Imported by the way store and its SRAM wrappers.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_LOOKUP  = 2'b01,
    OP_STORE   = 2'b10,
    OP_FILL    = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/sram_1rw.sv
// Single-port RAM model, byte-masked write, 1-cycle read.
// Stands in for the vendor macro; no reset on contents.
module sram_1rw #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int MW = (WIDTH + 7) / 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [MW-1:0]    wmask_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (wmask_i[i/8]) begin
            mem[addr_i][i] <= wdata_i[i];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/cache_way_store.sv
// N-way tag+data store: lookup, masked store, fill with
// invalid-first/round-robin victim, and flush sweep.
module cache_way_store
  import cache_pkg::*;
#(
  parameter int TAG_W  = 21,
  parameter int DATA_W = 128,
  parameter int SET_W  = 7,
  parameter int WAYS   = 2,
  localparam int WAY_W = $clog2(WAYS),
  localparam int MSK_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              flush_busy_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [SET_W-1:0]  req_set_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic [WAY_W-1:0]  req_way_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [MSK_W-1:0]  req_wmask_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [WAY_W-1:0]  resp_way_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [WAY_W-1:0]  resp_victim_o
);

  localparam int SETS  = 2 ** SET_W;
  localparam int TMSK  = (TAG_W + 7) / 8;

  state_e           state_q, state_d;
  logic [SET_W-1:0] flush_cnt_q;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  op_e              op;
  logic             accept;
  logic [WAYS-1:0]  set_valid;
  logic [WAY_W-1:0] victim;
  logic             use_rr;

  logic             resp_v_q;
  op_e              resp_op_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic [WAYS-1:0]  resp_vld_q;
  logic [WAY_W-1:0] resp_vic_q;

  logic [TAG_W-1:0]  tag_rd  [WAYS];
  logic [DATA_W-1:0] data_rd [WAYS];
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic              lookup_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == ST_FLUSH) ?
                     flush_cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush_i) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_cnt_q == SET_W'(SETS - 1))
                  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE) && !flush_i;
    flush_busy_o = (state_q == ST_FLUSH);
  end

  assign op        = op_e'(req_op_i);
  assign accept    = req_valid_i && req_ready_o;
  assign set_valid = valid_q[req_set_i];

  // Lowest invalid way wins; RR only when the set is full.
  always_comb begin
    victim = rr_q[req_set_i];
    use_rr = 1'b1;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!set_valid[i]) begin
        victim = WAY_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
      rr_q[flush_cnt_q]    <= '0;
    end else if (accept && op == OP_FILL) begin
      valid_q[req_set_i][victim] <= 1'b1;
      if (use_rr)
        rr_q[req_set_i] <= rr_q[req_set_i] + 1'b1;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic fill_w, store_w, rd_w;
    assign fill_w  = accept && op == OP_FILL &&
                     victim == WAY_W'(w);
    assign store_w = accept && op == OP_STORE &&
                     req_way_i == WAY_W'(w);
    assign rd_w    = accept && op == OP_LOOKUP;

    sram_1rw #(.WIDTH(TAG_W), .DEPTH(SETS)) u_tag (
      .clk_i   (clk_i),
      .en_i    (fill_w || rd_w),
      .we_i    (fill_w),
      .addr_i  (req_set_i),
      .wdata_i (req_tag_i),
      .wmask_i ({TMSK{1'b1}}),
      .rdata_o (tag_rd[w])
    );

    sram_1rw #(.WIDTH(DATA_W), .DEPTH(SETS)) u_data (
      .clk_i   (clk_i),
      .en_i    (fill_w || store_w || rd_w),
      .we_i    (fill_w || store_w),
      .addr_i  (req_set_i),
      .wdata_i (req_data_i),
      .wmask_i (fill_w ? {MSK_W{1'b1}} : req_wmask_i),
      .rdata_o (data_rd[w])
    );

    assign hit_vec[w] = resp_vld_q[w] &&
                        tag_rd[w] == resp_tag_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_v_q   <= 1'b0;
      resp_op_q  <= OP_ILLEGAL;
      resp_way_q <= '0;
      resp_tag_q <= '0;
      resp_vld_q <= '0;
      resp_vic_q <= '0;
    end else begin
      resp_v_q <= accept && op != OP_ILLEGAL;
      if (accept) begin
        resp_op_q  <= op;
        resp_way_q <= (op == OP_STORE) ? req_way_i : victim;
        resp_tag_q <= req_tag_i;
        resp_vld_q <= set_valid;
        resp_vic_q <= victim;
      end
    end
  end

  assign lookup_q = resp_v_q && resp_op_q == OP_LOOKUP;

  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  always_comb begin
    resp_valid_o  = resp_v_q;
    resp_hit_o    = lookup_q && |hit_vec;
    resp_data_o   = resp_hit_o ? data_rd[hit_way] : '0;
    resp_victim_o = lookup_q ? resp_vic_q : '0;
    resp_way_o    = '0;
    if (lookup_q) begin
      if (resp_hit_o) resp_way_o = hit_way;
    end else if (resp_v_q) begin
      resp_way_o = resp_way_q;
    end
  end

  a_one_hit: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    lookup_q |-> $onehot0(hit_vec)
  );

endmodule

// File: tb/tb_cache_way_store.sv
// Directed bench for cache_way_store with hand-computed
// expectations for lookup, fill, store and flush.
module tb_cache_way_store;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         flush_busy_o;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [1:0]   req_op_i = 2'b00;
  logic [6:0]   req_set_i = '0;
  logic [20:0]  req_tag_i = '0;
  logic         req_way_i = 1'b0;
  logic [127:0] req_data_i = '0;
  logic [15:0]  req_wmask_i = '0;
  logic         resp_valid_o;
  logic         resp_hit_o;
  logic         resp_way_o;
  logic [127:0] resp_data_o;
  logic         resp_victim_o;

  int vectors = 0;
  int errors  = 0;
  int busy_n;

  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] FL = 2'b11;

  localparam logic [127:0] D0 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] D1 = 128'h1111111111111111_2222222222222222;
  localparam logic [127:0] D2 = 128'h3333333333333333_4444444444444444;
  localparam logic [127:0] D3 = 128'h5555555555555555_6666666666666666;
  localparam logic [127:0] D4 = 128'h7777777777777777_8888888888888888;
  localparam logic [127:0] D3S = 128'h5555555555555555_66666666666666ff;

  cache_way_store dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .flush_busy_o  (flush_busy_o),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_set_i     (req_set_i),
    .req_tag_i     (req_tag_i),
    .req_way_i     (req_way_i),
    .req_data_i    (req_data_i),
    .req_wmask_i   (req_wmask_i),
    .resp_valid_o  (resp_valid_o),
    .resp_hit_o    (resp_hit_o),
    .resp_way_o    (resp_way_o),
    .resp_data_o   (resp_data_o),
    .resp_victim_o (resp_victim_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] op,
                     input logic [6:0] set,
                     input logic [20:0] tag,
                     input logic way,
                     input logic [127:0] data,
                     input logic [15:0] mask);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_set_i   = set;
    req_tag_i   = tag;
    req_way_i   = way;
    req_data_i  = data;
    req_wmask_i = mask;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic fill(input string nm, input logic [6:0] set,
                      input logic [20:0] tag,
                      input logic [127:0] data,
                      input logic exp_way);
    req(FL, set, tag, 1'b0, data, 16'h0);
    chk({nm, "_vld"}, resp_valid_o, 1'b1);
    chk({nm, "_way"}, resp_way_o, exp_way);
    chk({nm, "_hit"}, resp_hit_o, 1'b0);
  endtask

  task automatic look(input string nm, input logic [6:0] set,
                      input logic [20:0] tag, input logic hit,
                      input logic way, input logic [127:0] data,
                      input logic vic);
    req(LK, set, tag, 1'b0, '0, 16'h0);
    chk({nm, "_vld"}, resp_valid_o, 1'b1);
    chk({nm, "_hit"}, resp_hit_o, hit);
    chk({nm, "_way"}, resp_way_o, way);
    chk({nm, "_data"}, resp_data_o, data);
    chk({nm, "_vic"}, resp_victim_o, vic);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_rvalid", resp_valid_o, 1'b0);
    chk("rst_busy", flush_busy_o, 1'b0);
    chk("rst_data", resp_data_o, '0);

    look("t1_miss", 7'd5, 21'h1abcd, 1'b0, 1'b0, '0, 1'b0);

    fill("t2_fill", 7'd5, 21'h1abcd, D0, 1'b0);
    look("t2_hit", 7'd5, 21'h1abcd, 1'b1, 1'b0, D0, 1'b1);

    fill("t3_f1", 7'd5, 21'h00111, D1, 1'b1);
    fill("t3_f2", 7'd5, 21'h00222, D2, 1'b0);
    fill("t3_f3", 7'd5, 21'h00333, D3, 1'b1);
    look("t3_old", 7'd5, 21'h1abcd, 1'b0, 1'b0, '0, 1'b0);
    look("t3_w1", 7'd5, 21'h00333, 1'b1, 1'b1, D3, 1'b0);
    look("t3_w0", 7'd5, 21'h00222, 1'b1, 1'b0, D2, 1'b0);

    req(ST, 7'd5, 21'h0, 1'b1, 128'hff, 16'h0001);
    chk("t4_st_vld", resp_valid_o, 1'b1);
    chk("t4_st_hit", resp_hit_o, 1'b0);
    chk("t4_st_way", resp_way_o, 1'b1);
    chk("t4_st_data", resp_data_o, '0);
    look("t4_look", 7'd5, 21'h00333, 1'b1, 1'b1, D3S, 1'b0);

    req(2'b00, 7'd5, 21'h00333, 1'b0, '0, 16'h0);
    chk("ill_vld", resp_valid_o, 1'b0);

    // leave RR[5]=1 and a valid line in set 9 before flushing
    fill("pre_f4", 7'd5, 21'h00444, D4, 1'b0);
    fill("pre_s9", 7'd9, 21'h00999, D1, 1'b0);

    @(negedge clk);
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_op_i    = FL;
    req_set_i   = 7'd9;
    req_tag_i   = 21'h00aaa;
    #1;
    chk("t5_ready", req_ready_o, 1'b0);
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    chk("t5_noresp", resp_valid_o, 1'b0);
    busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!flush_busy_o) break;
      busy_n++;
      @(posedge clk);
      #1;
    end
    chk("t5_busy_cycles", busy_n, 128);
    chk("t5_ready_after", req_ready_o, 1'b1);
    look("t5_s5", 7'd5, 21'h00444, 1'b0, 1'b0, '0, 1'b0);
    look("t5_s9", 7'd9, 21'h00999, 1'b0, 1'b0, '0, 1'b0);
    look("t5_s9b", 7'd9, 21'h00aaa, 1'b0, 1'b0, '0, 1'b0);
    fill("t5_r0", 7'd5, 21'h00501, D1, 1'b0);
    fill("t5_r1", 7'd5, 21'h00502, D2, 1'b1);
    fill("t5_r2", 7'd5, 21'h00503, D3, 1'b0);

    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("t6_busy", flush_busy_o, 1'b1);
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("t6_busy_rst", flush_busy_o, 1'b0);
    chk("t6_rvalid_rst", resp_valid_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("t6_ready", req_ready_o, 1'b1);
    look("t6_s5", 7'd5, 21'h00503, 1'b0, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: bench did not finish");
  end

endmodule
